// File: rtl/mips_timer_pkg.sv
// Shared constants for the mips_timer bus peripheral: register offsets,
// CTRL/STATUS bit positions, reset values and the CTRL register layout.
package mips_timer_pkg;

    localparam logic [4:0] OFS_CTRL    = 5'h00;
    localparam logic [4:0] OFS_COUNT   = 5'h04;
    localparam logic [4:0] OFS_COMPARE = 5'h08;
    localparam logic [4:0] OFS_STATUS  = 5'h0C;
    localparam logic [4:0] OFS_CAPTURE = 5'h10;

    localparam int CTRL_EN         = 0;
    localparam int CTRL_AUTORELOAD = 1;
    localparam int CTRL_IRQ_EN     = 2;
    localparam int CTRL_PS_LSB     = 8;
    localparam int CTRL_PS_MSB     = 15;

    localparam int STAT_MATCH   = 0;
    localparam int STAT_CAPTURE = 1;

    localparam logic [31:0] COMPARE_RST = 32'hFFFF_FFFF;

    typedef struct packed {
        logic [7:0] prescale;
        logic       irq_en;
        logic       autoreload;
        logic       en;
    } ctrl_t;

    // Bus view of CTRL; unimplemented bits read as zero.
    function automatic logic [31:0] ctrl_to_word(input ctrl_t c);
        logic [31:0] w;
        w = '0;
        w[CTRL_EN]                 = c.en;
        w[CTRL_AUTORELOAD]         = c.autoreload;
        w[CTRL_IRQ_EN]             = c.irq_en;
        w[CTRL_PS_MSB:CTRL_PS_LSB] = c.prescale;
        return w;
    endfunction

endpackage

// File: rtl/mips_timer_prescaler.sv
// Prescaler for mips_timer: emits one tick every prescale+1 enabled cycles.
// The count is held at zero while disabled and restarted on any CTRL write.
module mips_timer_prescaler
    import mips_timer_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [7:0] prescale,
    input  logic       restart,
    output logic       tick
);

    logic [7:0] r_pcnt;
    logic       w_wrap;

    assign w_wrap = (r_pcnt == prescale);
    assign tick   = en & w_wrap;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pcnt <= '0;
        end else if (restart || !en || w_wrap) begin
            r_pcnt <= '0;
        end else begin
            r_pcnt <= r_pcnt + 8'd1;
        end
    end

endmodule

// File: rtl/mips_timer.sv
// Memory-mapped timer on the MIPS data bus: combinational loads, clocked stores,
// compare-match with one-shot/auto-reload. Optional capture input: MIPS_TIMER_CAPTURE_EN.
module mips_timer
    import mips_timer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'hFFFF_0000
) (
    input  logic        clk,
    input  logic        reset,
`ifdef MIPS_TIMER_CAPTURE_EN
    input  logic        capture_in,
`endif
    input  logic        memwrite,
    input  logic [31:0] memaddr,
    input  logic [31:0] memwritedata,
    output logic [31:0] memreaddata,
    output logic        sel,
    output logic        irq
);

    ctrl_t       r_ctrl;
    logic [31:0] r_count;
    logic [31:0] r_compare;
    logic        r_match;

    logic [4:0]  w_ofs;
    logic        w_wr;
    logic        w_wr_ctrl;
    logic        w_wr_count;
    logic        w_wr_compare;
    logic        w_wr_status;
    logic        w_tick;
    logic        w_hit;
    logic        w_match_evt;
    logic [31:0] w_count_next;
    logic [31:0] w_status;
    logic [31:0] w_capture;
    logic        w_cap_flag;
    logic        w_unused;

    assign w_unused = &{1'b0, memaddr[1:0]};

    assign sel          = (memaddr[31:5] == BASE_ADDR[31:5]);
    assign w_ofs        = {memaddr[4:2], 2'b00};
    assign w_wr         = memwrite & sel;
    assign w_wr_ctrl    = w_wr & (w_ofs == OFS_CTRL);
    assign w_wr_count   = w_wr & (w_ofs == OFS_COUNT);
    assign w_wr_compare = w_wr & (w_ofs == OFS_COMPARE);
    assign w_wr_status  = w_wr & (w_ofs == OFS_STATUS);

    mips_timer_prescaler u_prescaler (
        .clk      (clk),
        .reset    (reset),
        .en       (r_ctrl.en),
        .prescale (r_ctrl.prescale),
        .restart  (w_wr_ctrl),
        .tick     (w_tick)
    );

    assign w_hit       = (r_count == r_compare);
    assign w_match_evt = w_tick & w_hit;

    // A CPU store to COUNT overrides whatever the tick would have done.
    always_comb begin
        w_count_next = r_count;
        if (w_wr_count) begin
            w_count_next = memwritedata;
        end else if (w_tick) begin
            if (w_hit) begin
                w_count_next = r_ctrl.autoreload ? 32'd0 : r_count;
            end else begin
                w_count_next = r_count + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ctrl    <= '0;
            r_count   <= '0;
            r_compare <= COMPARE_RST;
            r_match   <= 1'b0;
        end else begin
            if (w_wr_ctrl) begin
                r_ctrl.en         <= memwritedata[CTRL_EN];
                r_ctrl.autoreload <= memwritedata[CTRL_AUTORELOAD];
                r_ctrl.irq_en     <= memwritedata[CTRL_IRQ_EN];
                r_ctrl.prescale   <= memwritedata[CTRL_PS_MSB:CTRL_PS_LSB];
            end else if (w_match_evt && !r_ctrl.autoreload) begin
                r_ctrl.en <= 1'b0;
            end

            r_count <= w_count_next;

            if (w_wr_compare) begin
                r_compare <= memwritedata;
            end

            // Hardware set wins over a same-cycle write-1-to-clear.
            if (w_match_evt) begin
                r_match <= 1'b1;
            end else if (w_wr_status && memwritedata[STAT_MATCH]) begin
                r_match <= 1'b0;
            end
        end
    end

`ifdef MIPS_TIMER_CAPTURE_EN
    logic        r_cap_sync1;
    logic        r_cap_sync2;
    logic        r_cap_prev;
    logic        r_cap_flag;
    logic [31:0] r_capture;
    logic        w_cap_edge;

    assign w_cap_edge = r_cap_sync2 & ~r_cap_prev;

    // CAPTURE takes the COUNT value as it stands after this edge, three edges after capture_in rises.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cap_sync1 <= 1'b0;
            r_cap_sync2 <= 1'b0;
            r_cap_prev  <= 1'b0;
            r_cap_flag  <= 1'b0;
            r_capture   <= '0;
        end else begin
            r_cap_sync1 <= capture_in;
            r_cap_sync2 <= r_cap_sync1;
            r_cap_prev  <= r_cap_sync2;
            if (w_cap_edge) begin
                r_capture  <= w_count_next;
                r_cap_flag <= 1'b1;
            end else if (w_wr_status && memwritedata[STAT_CAPTURE]) begin
                r_cap_flag <= 1'b0;
            end
        end
    end

    assign w_capture  = r_capture;
    assign w_cap_flag = r_cap_flag;
`else
    assign w_capture  = 32'd0;
    assign w_cap_flag = 1'b0;
`endif

    always_comb begin
        w_status               = '0;
        w_status[STAT_MATCH]   = r_match;
        w_status[STAT_CAPTURE] = w_cap_flag;
    end

    always_comb begin
        memreaddata = 32'd0;
        if (sel) begin
            case (w_ofs)
                OFS_CTRL:    memreaddata = ctrl_to_word(r_ctrl);
                OFS_COUNT:   memreaddata = r_count;
                OFS_COMPARE: memreaddata = r_compare;
                OFS_STATUS:  memreaddata = w_status;
                OFS_CAPTURE: memreaddata = w_capture;
                default:     memreaddata = 32'd0;
            endcase
        end
    end

    assign irq = (r_match | w_cap_flag) & r_ctrl.irq_en;

endmodule

// File: tb/tb_mips_timer.sv
// Directed bench for mips_timer; define MIPS_TIMER_CAPTURE_EN to cover the capture input.
module tb_mips_timer;
    import mips_timer_pkg::*;

    localparam logic [31:0] BASE = 32'hFFFF_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        memwrite = 1'b0;
    logic [31:0] memaddr = 32'd0;
    logic [31:0] memwritedata = 32'd0;
    logic [31:0] memreaddata;
    logic        sel;
    logic        irq;
`ifdef MIPS_TIMER_CAPTURE_EN
    logic        capture_in = 1'b0;
`endif

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    mips_timer #(.BASE_ADDR(BASE)) dut (
        .clk          (clk),
        .reset        (reset),
`ifdef MIPS_TIMER_CAPTURE_EN
        .capture_in   (capture_in),
`endif
        .memwrite     (memwrite),
        .memaddr      (memaddr),
        .memwritedata (memwritedata),
        .memreaddata  (memreaddata),
        .sel          (sel),
        .irq          (irq)
    );

    // Called at a falling edge; the store lands on the next rising edge and
    // the task returns at the following falling edge.
    task automatic bus_write(input logic [4:0] ofs, input logic [31:0] data);
        memaddr      = BASE | {27'd0, ofs};
        memwritedata = data;
        memwrite     = 1'b1;
        @(negedge clk);
        memwrite     = 1'b0;
    endtask

    task automatic bus_read(input logic [4:0] ofs, output logic [31:0] data);
        memaddr = BASE | {27'd0, ofs};
        #1;
        data = memreaddata;
    endtask

    task automatic test_reset();
        logic [4:0]  ofs_tab[8];
        logic [31:0] exp_tab[8];
        logic [31:0] rd;
        ofs_tab = '{5'h00, 5'h04, 5'h08, 5'h0C, 5'h10, 5'h14, 5'h18, 5'h1C};
        exp_tab = '{32'h0, 32'h0, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        reset = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            bus_read(ofs_tab[i], rd);
            n_total++;
            if (rd !== exp_tab[i]) $display("FAIL reset_reg_%h: got %h want %h", ofs_tab[i], rd, exp_tab[i]);
            else n_pass++;
        end
        n_total++;
        if (sel !== 1'b1) $display("FAIL reset_sel_in_window: got %b want 1", sel);
        else n_pass++;
        n_total++;
        if (irq !== 1'b0) $display("FAIL reset_irq: got %b want 0", irq);
        else n_pass++;
        memaddr = 32'h0000_1000;
        #1;
        n_total++;
        if (sel !== 1'b0) $display("FAIL reset_sel_outside: got %b want 0", sel);
        else n_pass++;
        n_total++;
        if (memreaddata !== 32'h0) $display("FAIL reset_rdata_outside: got %h want 0", memreaddata);
        else n_pass++;
    endtask

    task automatic test_autoreload();
        logic [31:0] exp_cnt[5];
        logic        exp_m[5];
        logic [31:0] rd;
        exp_cnt = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd0};
        exp_m   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        @(negedge clk);
        bus_write(OFS_COMPARE, 32'd3);
        bus_write(OFS_CTRL, 32'h0000_0003);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            bus_read(OFS_COUNT, rd);
            n_total++;
            if (rd !== exp_cnt[i]) $display("FAIL ar_count_%0d: got %h want %h", i, rd, exp_cnt[i]);
            else n_pass++;
            bus_read(OFS_STATUS, rd);
            n_total++;
            if (rd[0] !== exp_m[i]) $display("FAIL ar_match_%0d: got %b want %b", i, rd[0], exp_m[i]);
            else n_pass++;
        end
        // Clear the match, then it must reappear exactly 4 cycles after the previous set.
        bus_write(OFS_STATUS, 32'h1);
        bus_read(OFS_STATUS, rd);
        n_total++;
        if (rd[0] !== 1'b0) $display("FAIL ar_w1c: got %b want 0", rd[0]);
        else n_pass++;
        repeat (2) @(negedge clk);
        bus_read(OFS_STATUS, rd);
        n_total++;
        if (rd[0] !== 1'b0) $display("FAIL ar_period_early: got %b want 0", rd[0]);
        else n_pass++;
        @(negedge clk);
        bus_read(OFS_STATUS, rd);
        n_total++;
        if (rd[0] !== 1'b1) $display("FAIL ar_period: got %b want 1", rd[0]);
        else n_pass++;
        bus_read(OFS_COUNT, rd);
        n_total++;
        if (rd !== 32'd0) $display("FAIL ar_reload: got %h want 0", rd);
        else n_pass++;
        @(negedge clk);
        bus_write(OFS_CTRL, 32'h0);
    endtask

    task automatic test_oneshot();
        logic [31:0] rd;
        logic [31:0] exp_c;
        bus_write(OFS_COUNT, 32'd0);
        bus_write(OFS_STATUS, 32'h1);
        bus_write(OFS_COMPARE, 32'd2);
        bus_write(OFS_CTRL, 32'h0000_0401);
        for (int c = 1; c <= 20; c++) begin
            if (c > 1) @(negedge clk);
            exp_c = (c <= 5) ? 32'd0 : (c <= 10) ? 32'd1 : 32'd2;
            bus_read(OFS_COUNT, rd);
            n_total++;
            if (rd !== exp_c) $display("FAIL os_count_c%0d: got %h want %h", c, rd, exp_c);
            else n_pass++;
            if (c == 15 || c == 16) begin
                bus_read(OFS_STATUS, rd);
                n_total++;
                if (rd[0] !== (c == 16)) $display("FAIL os_match_c%0d: got %b want %b", c, rd[0], (c == 16));
                else n_pass++;
                bus_read(OFS_CTRL, rd);
                n_total++;
                if (rd !== ((c == 16) ? 32'h400 : 32'h401)) $display("FAIL os_ctrl_c%0d: got %h want %h", c, rd, ((c == 16) ? 32'h400 : 32'h401));
                else n_pass++;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_irq();
        logic [31:0] rd;
        n_total++;
        if (irq !== 1'b0) $display("FAIL irq_masked: got %b want 0", irq);
        else n_pass++;
        bus_write(OFS_CTRL, 32'h4);
        n_total++;
        if (irq !== 1'b1) $display("FAIL irq_enable_pending: got %b want 1", irq);
        else n_pass++;
        bus_write(OFS_STATUS, 32'h1);
        n_total++;
        if (irq !== 1'b0) $display("FAIL irq_w1c: got %b want 0", irq);
        else n_pass++;
        bus_write(OFS_COUNT, 32'd0);
        bus_write(OFS_CTRL, 32'h5);
        repeat (2) @(negedge clk);
        // This store lands on the same edge as the COUNT==COMPARE tick.
        bus_write(OFS_STATUS, 32'h1);
        bus_read(OFS_STATUS, rd);
        n_total++;
        if (rd[0] !== 1'b1) $display("FAIL irq_set_beats_clear: got %b want 1", rd[0]);
        else n_pass++;
        n_total++;
        if (irq !== 1'b1) $display("FAIL irq_after_race: got %b want 1", irq);
        else n_pass++;
        bus_read(OFS_CTRL, rd);
        n_total++;
        if (rd !== 32'h4) $display("FAIL irq_oneshot_ctrl: got %h want 00000004", rd);
        else n_pass++;
        @(negedge clk);
        bus_write(OFS_STATUS, 32'h1);
        n_total++;
        if (irq !== 1'b0) $display("FAIL irq_final_clear: got %b want 0", irq);
        else n_pass++;
    endtask

    task automatic test_wrap();
        logic [31:0] exp_c[4];
        logic [31:0] rd;
        exp_c = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0, 32'h1};
        bus_write(OFS_COMPARE, 32'd5);
        bus_write(OFS_COUNT, 32'hFFFF_FFFE);
        bus_write(OFS_CTRL, 32'h1);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            bus_read(OFS_COUNT, rd);
            n_total++;
            if (rd !== exp_c[i]) $display("FAIL wrap_count_%0d: got %h want %h", i, rd, exp_c[i]);
            else n_pass++;
        end
        bus_read(OFS_STATUS, rd);
        n_total++;
        if (rd !== 32'h0) $display("FAIL wrap_no_flag: got %h want 0", rd);
        else n_pass++;
        bus_write(OFS_COUNT, 32'd100);
        bus_read(OFS_COUNT, rd);
        n_total++;
        if (rd !== 32'd100) $display("FAIL write_beats_tick: got %0d want 100", rd);
        else n_pass++;
        @(negedge clk);
        bus_read(OFS_COUNT, rd);
        n_total++;
        if (rd !== 32'd101) $display("FAIL count_after_write: got %0d want 101", rd);
        else n_pass++;
        @(negedge clk);
        bus_write(OFS_CTRL, 32'h0);
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd;
        bus_write(OFS_COMPARE, 32'h1234_5678);
        bus_write(OFS_COUNT, 32'h0000_00A5);
        bus_read(OFS_COMPARE, rd);
        n_total++;
        if (rd !== 32'h1234_5678) $display("FAIL b2b_compare: got %h want 12345678", rd);
        else n_pass++;
        bus_read(OFS_COUNT, rd);
        n_total++;
        if (rd !== 32'h0000_00A5) $display("FAIL b2b_count: got %h want 000000a5", rd);
        else n_pass++;
        @(negedge clk);
        memaddr = 32'h0000_1004; memwritedata = 32'd77; memwrite = 1'b1;
        @(negedge clk);
        memaddr = BASE + 32'h24;
        #1;
        n_total++;
        if (sel !== 1'b0) $display("FAIL sel_next_window: got %b want 0", sel);
        else n_pass++;
        @(negedge clk);
        memwrite = 1'b0;
        bus_read(OFS_COUNT, rd);
        n_total++;
        if (rd !== 32'h0000_00A5) $display("FAIL ignore_outside_write: got %h want 000000a5", rd);
        else n_pass++;
        @(negedge clk);
        bus_write(5'h14, 32'hDEAD_BEEF);
        bus_read(5'h14, rd);
        n_total++;
        if (rd !== 32'h0) $display("FAIL reserved_reads_zero: got %h want 0", rd);
        else n_pass++;
        @(negedge clk);
        bus_write(OFS_CTRL, 32'hFFFF_FFFF);
        bus_read(OFS_CTRL, rd);
        n_total++;
        if (rd !== 32'h0000_FF07) $display("FAIL ctrl_mask: got %h want 0000ff07", rd);
        else n_pass++;
        @(negedge clk);
        bus_write(OFS_CTRL, 32'h0);
        memaddr = BASE + 32'h7;
        #1;
        n_total++;
        if (memreaddata !== 32'h0000_00A5) $display("FAIL byte_offset_alias: got %h want 000000a5", memreaddata);
        else n_pass++;
        @(negedge clk);
    endtask

`ifdef MIPS_TIMER_CAPTURE_EN
    task automatic test_capture();
        logic [31:0] rd;
        bus_write(OFS_STATUS, 32'h3);
        bus_write(OFS_COUNT, 32'd47);
        bus_write(OFS_CTRL, 32'h1);
        repeat (3) @(negedge clk);
        bus_read(OFS_COUNT, rd);
        n_total++;
        if (rd !== 32'd50) $display("FAIL cap_count_setup: got %0d want 50", rd);
        else n_pass++;
        capture_in = 1'b1;
        @(negedge clk);
        capture_in = 1'b0;
        bus_read(OFS_CAPTURE, rd);
        n_total++;
        if (rd !== 32'd0) $display("FAIL cap_early_1: got %0d want 0", rd);
        else n_pass++;
        @(negedge clk);
        bus_read(OFS_CAPTURE, rd);
        n_total++;
        if (rd !== 32'd0) $display("FAIL cap_early_2: got %0d want 0", rd);
        else n_pass++;
        @(negedge clk);
        bus_read(OFS_CAPTURE, rd);
        n_total++;
        if (rd !== 32'd53) $display("FAIL cap_value: got %0d want 53", rd);
        else n_pass++;
        bus_read(OFS_STATUS, rd);
        n_total++;
        if (rd !== 32'h2) $display("FAIL cap_status: got %h want 2", rd);
        else n_pass++;
        bus_write(OFS_CTRL, 32'h5);
        n_total++;
        if (irq !== 1'b1) $display("FAIL cap_irq: got %b want 1", irq);
        else n_pass++;
    endtask
`endif

    task automatic test_async_reset();
        logic [4:0]  ofs_tab[5];
        logic [31:0] exp_tab[5];
        logic [31:0] rd;
        ofs_tab = '{OFS_CTRL, OFS_COUNT, OFS_COMPARE, OFS_STATUS, OFS_CAPTURE};
        exp_tab = '{32'h0, 32'h0, 32'hFFFF_FFFF, 32'h0, 32'h0};
        bus_write(OFS_COMPARE, 32'h0000_1000);
        bus_write(OFS_COUNT, 32'd0);
        bus_write(OFS_CTRL, 32'h7);
        repeat (5) @(negedge clk);
        bus_read(OFS_COUNT, rd);
        n_total++;
        if (rd !== 32'd5) $display("FAIL rst_pre_count: got %0d want 5", rd);
        else n_pass++;
        // Reset lands mid-cycle, away from any rising edge.
        reset = 1'b0;
        #1;
        for (int i = 0; i < 5; i++) begin
            bus_read(ofs_tab[i], rd);
            n_total++;
            if (rd !== exp_tab[i]) $display("FAIL async_reset_%h: got %h want %h", ofs_tab[i], rd, exp_tab[i]);
            else n_pass++;
        end
        n_total++;
        if (irq !== 1'b0) $display("FAIL async_reset_irq: got %b want 0", irq);
        else n_pass++;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_autoreload();
        test_oneshot();
        test_irq();
        test_wrap();
        test_back_to_back();
`ifdef MIPS_TIMER_CAPTURE_EN
        test_capture();
`endif
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mips_timer.md
# mips_timer

Memory-mapped timer/counter peripheral that responds to the MIPS core's data-memory bus (memwrite/memaddr/memwritedata/memreaddata). It decodes a 32-byte window, answers loads combinationally in the same cycle as the core's MEM stage, and performs stores at the clock edge. It maintains a prescaled 32-bit counter with compare-match, one-shot/auto-reload modes and a level interrupt to the system.

## Interface

- BASE_ADDR, 32'hFFFF_0000, window base; bits [4:0] must be zero; window = BASE_ADDR..BASE_ADDR+0x1F
- clk  input  1  system clock, single clock domain
- reset  input  1  asynchronous, active-low reset
- memwrite  input  1  store strobe from core MEM stage
- memaddr  input  32  byte address from core; bits [1:0] ignored
- memwritedata  input  32  store data
- memreaddata  output  32  load data, combinational
- sel  output  1  high when memaddr falls in window (system mux select)
- irq  output  1  level interrupt = STATUS.match & CTRL.irq_en

## Operation

- Hit: sel = (memaddr[31:5] == BASE_ADDR[31:5]). Stores with memwrite & ~sel are ignored.
- Register map (word offsets):
  - 0x00 CTRL: [0] en, [1] autoreload, [2] irq_en, [15:8] prescale; other bits read 0
  - 0x04 COUNT: rw
  - 0x08 COMPARE: rw
  - 0x0C STATUS: [0] match, [1] capture; write-1-to-clear
  - 0x10 CAPTURE: ro (see Configuration)
  - 0x14–0x1C: read 0, writes ignored
- memreaddata = selected register when sel, else 32'h0.
- Prescaler: 8-bit counter `pcnt`. While en: if pcnt == prescale then tick=1 and pcnt←0, else pcnt←pcnt+1. prescale=0 gives a tick every cycle. While ~en, pcnt holds at 0.
- On tick:
  - if COUNT == COMPARE: STATUS.match←1; if autoreload, COUNT←0; else COUNT holds and CTRL.en←0 (one-shot).
  - otherwise COUNT←COUNT+1, wrapping 0xFFFF_FFFF→0 with no flag.
- Simultaneous events:
  - A CPU write to COUNT beats the tick update.
  - A CPU write to CTRL beats the one-shot clear of en.
  - A hardware set of a STATUS bit beats a W1C clear in the same cycle.
  - Any write to CTRL resets pcnt to 0.
- Reset (asynchronous, active-low, any time): CTRL=0, COUNT=0, COMPARE=32'hFFFF_FFFF, STATUS=0, CAPTURE=0, pcnt=0. Consequently irq=0 and sel/memreaddata follow memaddr combinationally.

## Timing

- Loads: zero latency. memreaddata is valid in the same cycle as memaddr, driven from registered state only.
- Stores: take effect at the rising clk edge where memwrite & sel. A load in the following cycle returns the new value.
- Match: STATUS.match and irq rise one cycle after the tick cycle in which COUNT == COMPARE.
- Period with autoreload: (COMPARE+1)·(prescale+1) cycles between match sets.
- irq has no pipeline delay beyond the STATUS/CTRL registers.

## Configuration

- MIPS_TIMER_CAPTURE_EN defined:
  - Adds input port capture_in (1 bit, asynchronous).
  - capture_in is synchronized with 2 flops. A rising edge detected on the synchronized signal latches COUNT into CAPTURE and sets STATUS.capture.
  - Edge-to-CAPTURE latency is 3 clk cycles.
  - irq = (STATUS.match | STATUS.capture) & irq_en.
- MIPS_TIMER_CAPTURE_EN undefined: no capture_in port; offset 0x10 and STATUS[1] read 0; irq = STATUS.match & irq_en.

## Structure

- Package mips_timer_pkg: register offset constants (OFS_CTRL/COUNT/COMPARE/STATUS/CAPTURE), CTRL and STATUS bit-position constants, COMPARE reset value.
- Sub-module mips_timer_prescaler: en, prescale[7:0] and restart in; tick out; contains pcnt.
- Top holds the register file, address decode, read mux and irq.

## Test plan

- Reset, then read every offset: CTRL=0, COUNT=0, COMPARE=FFFF_FFFF, STATUS=0; sel=0 and memreaddata=0 for address 0x0000_1000.
- COMPARE=3, CTRL=0x3 (en, autoreload, prescale 0): COUNT sequence 0,1,2,3,0; STATUS.match set 1 cycle after the COUNT==3 tick; period 4 cycles.
- CTRL=0x0000_0401 (prescale 4, one-shot), COMPARE=2: COUNT increments every 5 cycles; after match, en reads 0 and COUNT holds at 2.
- Set irq_en with match pending → irq=1. Write STATUS=1 → irq=0 next cycle. Write STATUS=1 in the same cycle as a new match → match stays 1.
- COUNT=FFFF_FFFE, COMPARE=5, prescale 0: COUNT wraps to 0 with no match. Also, a CPU write of COUNT=100 coinciding with a tick → reads 100.
- With MIPS_TIMER_CAPTURE_EN: a capture_in pulse while COUNT=50 (prescale 0) → CAPTURE=53 (3-cycle sync latency), STATUS.capture=1. Assert reset mid-count → all registers return to reset values immediately, asynchronously.
